// File: rtl/dac_pulse_scheduler.sv
// ============================================================================
// dac_pulse_scheduler : timed DAC pulse trains driven through an SPI master
// Optional SCHED_CLEAR_ON_ABORT_EN: abort pulses dac_clear instead of a zero write.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dac_pulse_scheduler #(
  parameter int                DATA_W    = 16,
  parameter int                CNT_W     = 24,
  parameter logic [DATA_W-1:0] ZERO_CODE = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] amplitude,
  input  logic [CNT_W-1:0]  pulse_width,
  input  logic [CNT_W-1:0]  gap_width,
  input  logic [15:0]       n_pulses,
  output logic              spi_req,
  output logic [DATA_W-1:0] spi_data,
  input  logic              spi_ack,
  output logic              dac_clear,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pulse_cnt
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WR_HI = 3'd1;
  localparam logic [2:0] HIGH  = 3'd2;
  localparam logic [2:0] WR_LO = 3'd3;
  localparam logic [2:0] LOW   = 3'd4;
  localparam logic [2:0] ABORT = 3'd5;

`ifdef SCHED_CLEAR_ON_ABORT_EN
  localparam bit CLR_ON_ABORT = 1'b1;
`else
  localparam bit CLR_ON_ABORT = 1'b0;
`endif

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] amp_q, amp_d;
  logic [CNT_W-1:0]  pw_q, pw_d, gw_q, gw_d;
  logic [15:0]       np_q, np_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       pulse_cnt_q, pulse_cnt_d;
  logic              spi_req_q, spi_req_d;
  logic [DATA_W-1:0] spi_data_q, spi_data_d;
  logic              done_q, done_d;
  logic              dac_clear_q, dac_clear_d;
  logic              stop_pend_q, stop_pend_d;

  logic [15:0] pulse_cnt_inc;
  logic        go_hi, go_abort, go_finish;

  assign pulse_cnt_inc = pulse_cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    amp_d       = amp_q;
    pw_d        = pw_q;
    gw_d        = gw_q;
    np_d        = np_q;
    cnt_d       = cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    spi_req_d   = spi_req_q;
    spi_data_d  = spi_data_q;
    done_d      = 1'b0;
    dac_clear_d = dac_clear_q;
    stop_pend_d = stop_pend_q;
    go_hi       = 1'b0;
    go_abort    = 1'b0;
    go_finish   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          amp_d       = amplitude;
          pw_d        = pulse_width;
          gw_d        = gap_width;
          np_d        = n_pulses;
          pulse_cnt_d = 16'd0;
          stop_pend_d = 1'b0;
          state_d     = WR_HI;
          spi_req_d   = 1'b1;
          spi_data_d  = amplitude;
        end
      end
      WR_HI: begin
        // A stop during a pending write is remembered until the ack lands.
        if (spi_ack) begin
          if (stop || stop_pend_q) begin
            go_abort = 1'b1;
          end else begin
            state_d   = HIGH;
            spi_req_d = 1'b0;
            cnt_d     = {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else if (stop) begin
          stop_pend_d = 1'b1;
        end
      end
      HIGH: begin
        if (stop) begin
          go_abort = 1'b1;
        end else if (cnt_q >= pw_q) begin
          state_d    = WR_LO;
          spi_req_d  = 1'b1;
          spi_data_d = ZERO_CODE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR_LO: begin
        if (spi_ack) begin
          pulse_cnt_d = pulse_cnt_inc;
          if (stop || stop_pend_q) begin
            go_abort = 1'b1;
          end else if (gw_q == '0) begin
            if (np_q == 16'd0 || pulse_cnt_inc < np_q) go_hi = 1'b1;
            else                                        go_finish = 1'b1;
          end else begin
            state_d   = LOW;
            spi_req_d = 1'b0;
            cnt_d     = {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else if (stop) begin
          stop_pend_d = 1'b1;
        end
      end
      LOW: begin
        if (stop) begin
          go_abort = 1'b1;
        end else if (cnt_q >= gw_q) begin
          if (np_q == 16'd0 || pulse_cnt_q < np_q) go_hi = 1'b1;
          else                                      go_finish = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ABORT: begin
        if (CLR_ON_ABORT) begin
          if (cnt_q >= CNT_W'(2)) go_finish = 1'b1;
          else                    cnt_d = cnt_q + 1'b1;
        end else if (spi_ack) begin
          go_finish = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_hi) begin
      state_d    = WR_HI;
      spi_req_d  = 1'b1;
      spi_data_d = amp_q;
    end
    if (go_abort) begin
      state_d     = ABORT;
      stop_pend_d = 1'b0;
      if (CLR_ON_ABORT) begin
        spi_req_d   = 1'b0;
        dac_clear_d = 1'b1;
        cnt_d       = {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        spi_req_d  = 1'b1;
        spi_data_d = ZERO_CODE;
      end
    end
    if (go_finish) begin
      state_d     = IDLE;
      spi_req_d   = 1'b0;
      spi_data_d  = ZERO_CODE;
      dac_clear_d = 1'b0;
      stop_pend_d = 1'b0;
      done_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      amp_q       <= '0;
      pw_q        <= '0;
      gw_q        <= '0;
      np_q        <= '0;
      cnt_q       <= '0;
      pulse_cnt_q <= '0;
      spi_req_q   <= 1'b0;
      spi_data_q  <= ZERO_CODE;
      done_q      <= 1'b0;
      dac_clear_q <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      amp_q       <= amp_d;
      pw_q        <= pw_d;
      gw_q        <= gw_d;
      np_q        <= np_d;
      cnt_q       <= cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      spi_req_q   <= spi_req_d;
      spi_data_q  <= spi_data_d;
      done_q      <= done_d;
      dac_clear_q <= dac_clear_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign spi_req   = spi_req_q;
  assign spi_data  = spi_data_q;
  assign dac_clear = dac_clear_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule

`default_nettype wire
